fixed_point_div: RTL

FIXED_POINT_DIV -- requirements
Module: fixed_point_div

---
 rtl/fixed_point_div.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fixed_point_div.sv
// ---------------------------------------------------------------------------
// fixed_point_div
//
// Sequential signed fixed-point divider. Computes
//   out = trunc_toward_zero((a * 2^FRAC_BITS) / b)
// and saturates the result to the WIDTH-bit signed range. The divide runs as
// a restoring divider on operand magnitudes, one quotient bit per clock, over
// a WIDTH+FRAC_BITS bit dividend. The sign is applied afterwards.
//
// Parameters
//   WIDTH      operand / result width in bits (default 32)
//   FRAC_BITS  fraction bits of the fixed-point format (default 16 -> Q15.16)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        request; a and b are sampled when start=1 and busy=0
//   a            signed dividend
//   b            signed divisor
//   out          signed quotient, registered, held until the next result
//   overflow     result was saturated (valid with done, held after)
//   div_by_zero  b was zero (valid with done, held after)
//   busy         high from the cycle after acceptance through the done cycle
//   done         one-cycle pulse, result valid
//
// Timing (start accepted at edge k)
//   b != 0 : CALC at edges k+1..k+WIDTH+FRAC_BITS, FIX at the next edge,
//            done high in the cycle after FIX.
//   b == 0 : result is written at edge k, done high after edge k+1.
// ---------------------------------------------------------------------------
module fixed_point_div #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  localparam int DW = WIDTH + FRAC_BITS;   // dividend / quotient width
  localparam int CW = $clog2(DW + 1);      // iteration counter width

  // Largest negative magnitude that still fits: 2^(WIDTH-1).
  localparam logic [DW-1:0]    NEG_LIM = DW'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [DW-1:0]    dvd;   // dividend shifting out, quotient shifting in
  logic [WIDTH:0]   rem;   // partial remainder, one guard bit for the shift
  logic [WIDTH-1:0] dsr;   // divisor magnitude
  logic             neg;   // result sign
  logic [CW-1:0]    cnt;

  // Magnitudes. Negating 0x80..0 wraps back to 0x80..0, which read as
  // unsigned is exactly 2^(WIDTH-1), so the most negative input is exact.
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

  // One restoring-division step.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] rem_sub;
  logic           q_bit;

  // Sign application and saturation of the finished quotient.
  logic             pos_ovf;
  logic             neg_ovf;
  logic [WIDTH-1:0] q_lo;
  logic [WIDTH-1:0] fix_out;
  logic             fix_ovf;

  // NOTE: every signal driven here gets a value on every path (defaults
  // first), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    rem_sh  = '0;
    rem_sub = '0;
    q_bit   = 1'b0;
    pos_ovf = 1'b0;
    neg_ovf = 1'b0;
    q_lo    = '0;
    fix_out = '0;
    fix_ovf = 1'b0;

    rem_sh  = (rem << 1) | {{WIDTH{1'b0}}, dvd[DW-1]};
    rem_sub = rem_sh - {1'b0, dsr};
    q_bit   = (rem_sh >= {1'b0, dsr});

    // Positive results fit only below 2^(WIDTH-1); negative ones may reach it.
    pos_ovf = |dvd[DW-1:WIDTH-1];
    neg_ovf = (dvd > NEG_LIM);
    q_lo    = dvd[WIDTH-1:0];

    if (neg) begin
      fix_out = neg_ovf ? NEG_MIN : (~q_lo + 1'b1);  // -0 wraps to 0
      fix_ovf = neg_ovf;
    end else begin
      fix_out = pos_ovf ? POS_MAX : q_lo;
      fix_ovf = pos_ovf;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      rem         <= '0;
      dsr         <= '0;
      neg         <= 1'b0;
      cnt         <= '0;
      out         <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            rem  <= '0;
            neg  <= a[WIDTH-1] ^ b[WIDTH-1];
            dvd  <= {a_mag, {FRAC_BITS{1'b0}}};
            dsr  <= b_mag;
            if (b == '0) begin
              // Result is known immediately; DONE raises done one edge later.
              out         <= a[WIDTH-1] ? NEG_MIN : POS_MAX;
              overflow    <= 1'b1;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          rem <= q_bit ? rem_sub : rem_sh;
          dvd <= {dvd[DW-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          out         <= fix_out;
          overflow    <= fix_ovf;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end

        DONE: begin
          // Entered with done=1 from FIX; entered with done=0 on a zero
          // divisor, in which case the pulse is raised here first.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
